tanimoto_threshold_cmp: RTL

Multi-lane successor to the single-lane Tanimoto threshold comparator. It compares LANES fingerprint pairs per cycle. For each lane it checks CntA+CntB against a threshold table entry indexed by CntC. The table is loaded at run time through a configuration port governed by a LOAD/RUN state machine. It sits between the popcount stage and the result collector, and adds aligned valid pipelining, degenerate-input handling, out-of-range detection and a saturating hit counter.

---
 rtl/tanimoto_pkg.sv | 22 ++
 rtl/tanimoto_threshold_cmp_if.sv | 38 +++
 rtl/tanimoto_threshold_cmp_lut.sv | 28 ++
 rtl/tanimoto_threshold_cmp.sv | 130 +++++++++++++
 4 files changed

// File: rtl/tanimoto_pkg.sv
// Shared definitions for the multi-lane Tanimoto threshold comparator:
// FSM encoding, popcount width derivation and lane-slice helper.
`ifndef TANIMOTO_PKG_SV
`define TANIMOTO_PKG_SV

// Lane k's field inside a flat LANES*w bus.
`define TT_LANE(k, w) ((k)*(w)) +: (w)

package tanimoto_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned vector_width);
    return $clog2(vector_width + 1);
  endfunction

endpackage

`endif

// File: rtl/tanimoto_threshold_cmp_if.sv
// Data, configuration and result bundle of the Tanimoto threshold comparator.
interface tanimoto_threshold_cmp_if
  import tanimoto_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = 920,
  parameter int unsigned LANES        = 4,
  parameter int unsigned CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
  parameter int unsigned HITCNT_WIDTH = 32
);

  logic [LANES*CNT_WIDTH-1:0] i_CntA;
  logic [LANES*CNT_WIDTH-1:0] i_CntB;
  logic [LANES*CNT_WIDTH-1:0] i_CntC;
  logic                       i_Valid;
  logic                       i_Cfg_WrEn;
  logic [CNT_WIDTH-1:0]       i_Cfg_Addr;
  logic [CNT_WIDTH:0]         i_Cfg_Din;
  logic                       i_Cfg_Done;
  logic                       i_HitCntClr;
  logic                       o_Ready;
  logic [LANES-1:0]           o_Hit;
  logic                       o_Valid;
  logic [HITCNT_WIDTH-1:0]    o_HitCnt;
  logic                       o_Err;

  modport master (
    output i_CntA, i_CntB, i_CntC, i_Valid,
    output i_Cfg_WrEn, i_Cfg_Addr, i_Cfg_Din, i_Cfg_Done, i_HitCntClr,
    input  o_Ready, o_Hit, o_Valid, o_HitCnt, o_Err
  );

  modport slave (
    input  i_CntA, i_CntB, i_CntC, i_Valid,
    input  i_Cfg_WrEn, i_Cfg_Addr, i_Cfg_Din, i_Cfg_Done, i_HitCntClr,
    output o_Ready, o_Hit, o_Valid, o_HitCnt, o_Err
  );

endinterface

// File: rtl/tanimoto_threshold_cmp_lut.sv
// Threshold table: one write port, one synchronous read port with enable.
// Contents are deliberately not reset.
module threshold_lut #(
  parameter int unsigned DEPTH      = 921,
  parameter int unsigned WIDTH      = 11,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tanimoto_threshold_cmp.sv
// Multi-lane Tanimoto threshold comparator: LOAD/RUN table loading, a fixed
// two-stage compare pipeline, sticky range error and a saturating hit counter.
module tanimoto_threshold_cmp
  import tanimoto_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = 920,
  parameter int unsigned LANES        = 4,
  parameter int unsigned CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
  parameter int unsigned HITCNT_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rstn,
  tanimoto_threshold_cmp_if.slave bus
);

  localparam int unsigned POPW = $clog2(LANES + 1);

  state_t                   state;
  logic                     cfg_oor;
  logic                     cfg_we;
  logic                     accept;
  logic                     flush;
  logic [LANES-1:0]         oor_in;
  logic [LANES-1:0]         zero_in;
  logic [CNT_WIDTH:0]       sum_in  [LANES];
  logic [CNT_WIDTH:0]       sum_q   [LANES];
  logic [CNT_WIDTH:0]       thr     [LANES];
  logic [LANES-1:0]         oor_q;
  logic [LANES-1:0]         zero_q;
  logic                     valid_q;
  logic [LANES-1:0]         hit_next;
  logic [POPW-1:0]          hit_pop;
  logic [HITCNT_WIDTH:0]    cnt_sum;

  assign cfg_oor = bus.i_Cfg_Addr > CNT_WIDTH'(VECTOR_WIDTH);
  assign cfg_we  = bus.i_Cfg_WrEn && !cfg_oor;
  // A write seen in RUN both leaves RUN and kills everything in flight.
  assign flush   = (state == ST_RUN) && bus.i_Cfg_WrEn;
  assign accept  = bus.i_Valid && (state == ST_RUN) && !bus.i_Cfg_WrEn;

  always_comb begin
    oor_in  = '0;
    zero_in = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      sum_in[k]  = {1'b0, bus.i_CntA[`TT_LANE(k, CNT_WIDTH)]}
                 + {1'b0, bus.i_CntB[`TT_LANE(k, CNT_WIDTH)]};
      oor_in[k]  = bus.i_CntC[`TT_LANE(k, CNT_WIDTH)] > CNT_WIDTH'(VECTOR_WIDTH);
      zero_in[k] = (sum_in[k] == '0);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    threshold_lut #(
      .DEPTH      (VECTOR_WIDTH + 1),
      .WIDTH      (CNT_WIDTH + 1),
      .ADDR_WIDTH (CNT_WIDTH)
    ) u_lut (
      .clk     (clk),
      .wr_en   (cfg_we),
      .wr_addr (bus.i_Cfg_Addr),
      .wr_data (bus.i_Cfg_Din),
      .rd_en   (accept && !oor_in[k]),
      .rd_addr (bus.i_CntC[`TT_LANE(k, CNT_WIDTH)]),
      .rd_data (thr[k])
    );
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sum_q  <= sum_in;
      zero_q <= zero_in;
      oor_q  <= oor_in;
    end
  end

  always_comb begin
    hit_next = '0;
    hit_pop  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      hit_next[k] = (sum_q[k] >= thr[k]) && !zero_q[k] && !oor_q[k];
      hit_pop     = hit_pop + POPW'(bus.o_Hit[k]);
    end
    cnt_sum = {1'b0, bus.o_HitCnt} + (HITCNT_WIDTH + 1)'(hit_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_LOAD;
      bus.o_Ready  <= 1'b0;
      valid_q      <= 1'b0;
      bus.o_Valid  <= 1'b0;
      bus.o_Hit    <= '0;
      bus.o_Err    <= 1'b0;
      bus.o_HitCnt <= '0;
    end else begin
      case (state)
        ST_LOAD: if (bus.i_Cfg_Done) begin
          state       <= ST_RUN;
          bus.o_Ready <= 1'b1;
        end
        ST_RUN: if (bus.i_Cfg_WrEn) begin
          state       <= ST_LOAD;
          bus.o_Ready <= 1'b0;
        end
        default: begin
          state       <= ST_LOAD;
          bus.o_Ready <= 1'b0;
        end
      endcase

      valid_q     <= accept;
      bus.o_Valid <= valid_q && !flush;
      if (valid_q && !flush) begin
        bus.o_Hit <= hit_next;
      end

      if ((bus.i_Cfg_WrEn && cfg_oor) || (accept && (|oor_in))) begin
        bus.o_Err <= 1'b1;
      end

      // Clear wins over the old total but still keeps this cycle's hits.
      if (bus.i_HitCntClr) begin
        bus.o_HitCnt <= bus.o_Valid ? HITCNT_WIDTH'(hit_pop) : '0;
      end else if (bus.o_Valid) begin
        bus.o_HitCnt <= cnt_sum[HITCNT_WIDTH] ? '1 : cnt_sum[HITCNT_WIDTH-1:0];
      end
    end
  end

endmodule
